// File: rtl/sram_fifo_reader.sv
// Read-side adapter for a BRAM-backed synchronous FIFO. Pops the FIFO on credit,
// follows the fixed BRAM read latency, catches the returning words in a small
// circular buffer and offers them downstream as a registered valid/ready stream.
module sram_fifo_reader #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned BUF_DEPTH    = READ_LATENCY + 2
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               flush_i,
  input  logic                               fifo_empty_i,
  output logic                               fifo_pop_o,
  input  logic [DATA_WIDTH-1:0]              fifo_data_i,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic [DATA_WIDTH-1:0]              data_o,
  output logic [$clog2(BUF_DEPTH+1)-1:0]     level_o
);

  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);
  localparam int unsigned PtrW = $clog2(BUF_DEPTH);
  localparam int unsigned InfW = $clog2(READ_LATENCY + 1);

  logic [DATA_WIDTH-1:0]   mem_q [BUF_DEPTH];
  logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]         count_q, count_d;
  logic [READ_LATENCY-1:0] ret_sr_q, ret_sr_d;
  logic [InfW-1:0]         inflight_q, inflight_d;
  logic                    flush_q;

  logic            ret_valid;
  logic            wr_en;
  logic            hs;
  logic [CntW:0]   credit_used;

  // Wrap for a possibly non-power-of-two depth.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(BUF_DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Credit check, handshake and return decode.
  always_comb begin
    credit_used = {1'b0, count_q} + (CntW + 1)'(inflight_q);
    // The FIFO applies flush a cycle late, so flush_q also blocks pops.
    fifo_pop_o  = !fifo_empty_i && !rst_i && !flush_i && !flush_q &&
                  (credit_used < (CntW + 1)'(BUF_DEPTH));
    ret_valid   = ret_sr_q[READ_LATENCY-1];
    // A word landing in the flush cycle is discarded.
    wr_en       = ret_valid && !flush_i;
    valid_o     = (count_q != '0) && !rst_i;
    level_o     = rst_i ? '0 : count_q;
    hs          = valid_o && ready_i;
    data_o      = mem_q[rd_ptr_q];
  end

  // Next-state for pointers, occupancy and in-flight tracking.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    ret_sr_d   = READ_LATENCY'({ret_sr_q, fifo_pop_o});
    inflight_d = inflight_q + InfW'(fifo_pop_o) - InfW'(ret_valid);
    if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (hs)    rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({wr_en, hs})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    // A handshake in the flush cycle still leaves the buffer, but the clear wins.
    if (flush_i) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      ret_sr_d   = '0;
      inflight_d = '0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      ret_sr_q   <= '0;
      inflight_q <= '0;
      flush_q    <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      ret_sr_q   <= ret_sr_d;
      inflight_q <= inflight_d;
      flush_q    <= flush_i;
    end
  end

  // Buffer storage; cleared on reset so data_o starts at zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q <= '{default: '0};
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= fifo_data_i;
    end
  end

  // The credit rule must keep a returning word from finding the buffer full.
  overflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
                               !(wr_en && (count_q == CntW'(BUF_DEPTH))));

endmodule

// File: tb/tb_sram_fifo_reader.sv
// Directed bench for sram_fifo_reader: one instance at read latency 1, one at 2,
// each fed by a small behavioural model of the BRAM FIFO.
module tb_sram_fifo_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance 1: READ_LATENCY = 1
  logic        rst1, flush1, pop1, ready1, valid1;
  logic        empty1 = 1'b1;
  logic [63:0] fdata1, dout1;
  logic [1:0]  lvl1;
  logic [63:0] mem1 [4096];
  int          wr1 = 0;
  int          rd1 = 0;
  logic [63:0] d1a = '0;

  // Instance 2: READ_LATENCY = 2
  logic        rst2, flush2, pop2, ready2, valid2;
  logic        empty2 = 1'b1;
  logic [63:0] fdata2, dout2;
  logic [2:0]  lvl2;
  logic [63:0] mem2 [4096];
  int          wr2 = 0;
  int          rd2 = 0;
  logic [63:0] d2a = '0;
  logic [63:0] d2b = '0;

  sram_fifo_reader #(.DATA_WIDTH(64), .READ_LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst1), .flush_i(flush1), .fifo_empty_i(empty1),
    .fifo_pop_o(pop1), .fifo_data_i(fdata1), .valid_o(valid1), .ready_i(ready1),
    .data_o(dout1), .level_o(lvl1)
  );

  sram_fifo_reader #(.DATA_WIDTH(64), .READ_LATENCY(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst2), .flush_i(flush2), .fifo_empty_i(empty2),
    .fifo_pop_o(pop2), .fifo_data_i(fdata2), .valid_o(valid2), .ready_i(ready2),
    .data_o(dout2), .level_o(lvl2)
  );

  // FIFO model 1: registered empty (stale for one cycle after flush), 1-cycle read.
  always @(posedge clk) begin
    if (rst1) begin
      rd1    <= wr1;
      empty1 <= 1'b1;
    end else begin
      if (pop1) d1a <= mem1[rd1[11:0]];
      if (flush1)    rd1 <= wr1;
      else if (pop1) rd1 <= rd1 + 1;
      empty1 <= (wr1 <= rd1 + (pop1 ? 1 : 0));
    end
  end
  assign fdata1 = d1a;

  // FIFO model 2: same, with a 2-cycle read pipeline.
  always @(posedge clk) begin
    if (rst2) begin
      rd2    <= wr2;
      empty2 <= 1'b1;
    end else begin
      if (pop2) d2a <= mem2[rd2[11:0]];
      d2b <= d2a;
      if (flush2)    rd2 <= wr2;
      else if (pop2) rd2 <= rd2 + 1;
      empty2 <= (wr2 <= rd2 + (pop2 ? 1 : 0));
    end
  end
  assign fdata2 = d2b;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push1(input logic [63:0] w);
    mem1[wr1[11:0]] = w;
    wr1++;
  endtask

  task automatic push2(input logic [63:0] w);
    mem2[wr2[11:0]] = w;
    wr2++;
  endtask

  function automatic logic [63:0] rw(input int i);
    return {32'(i) ^ 32'hDEAD_0000, 32'(i) + 32'h1000};
  endfunction

  initial begin
    int          exp;
    int          gap;
    int          pops;
    int          stab_err;
    bit          seen;
    bit          prev_stall;
    logic [63:0] prev_data;
    logic [2:0]  maxlvl;

    rst1 = 1'b1; rst2 = 1'b1; flush1 = 1'b0; flush2 = 1'b0;
    ready1 = 1'b1; ready2 = 1'b0;
    step; step; #1;
    check("rst_valid", 64'(valid1), 64'd0);
    check("rst_level", 64'(lvl1), 64'd0);
    check("rst_pop", 64'(pop1), 64'd0);
    check("rst_data", dout1, 64'd0);
    step; rst1 = 1'b0; rst2 = 1'b0;
    repeat (3) step;

    // First word, latency 1
    step; push1(64'hA5); #1;
    check("fw_pop_idle", 64'(pop1), 64'd0);
    step; #1;
    check("fw_pop_t", 64'(pop1), 64'd1);
    check("fw_valid_t", 64'(valid1), 64'd0);
    step; #1;
    check("fw_pop_t1", 64'(pop1), 64'd0);
    check("fw_valid_t1", 64'(valid1), 64'd0);
    step; #1;
    check("fw_valid_t2", 64'(valid1), 64'd1);
    check("fw_data_t2", dout1, 64'hA5);
    check("fw_level_t2", 64'(lvl1), 64'd1);
    step; #1;
    check("fw_level_t3", 64'(lvl1), 64'd0);
    check("fw_valid_t3", 64'(valid1), 64'd0);

    // Streaming, 100 words
    step;
    for (int i = 0; i < 100; i++) push1(64'(i));
    exp = 0; gap = 0; seen = 1'b0;
    for (int c = 0; c < 300 && exp < 100; c++) begin
      step; #1;
      if (valid1) begin
        check("stream_data", dout1, 64'(exp));
        exp++;
        seen = 1'b1;
      end else if (seen) begin
        gap++;
      end
    end
    check("stream_count", 64'(exp), 64'd100);
    check("stream_gap", 64'(gap), 64'd0);

    // Back-pressure, 10 words held
    step; ready1 = 1'b0;
    for (int i = 0; i < 10; i++) push1(64'(i));
    pops = 0;
    for (int c = 0; c < 20; c++) begin
      step; #1;
      if (pop1) pops++;
    end
    check("bp_pops", 64'(pops), 64'd3);
    check("bp_level", 64'(lvl1), 64'd3);
    check("bp_pop_held", 64'(pop1), 64'd0);
    check("bp_valid", 64'(valid1), 64'd1);
    check("bp_head", dout1, 64'd0);
    step; ready1 = 1'b1; #1;
    check("bp_resume_pop_r", 64'(pop1), 64'd0);
    check("bp_data", dout1, 64'd0);
    exp = 1;
    step; #1;
    check("bp_resume_pop", 64'(pop1), 64'd1);
    for (int c = 0; c < 100 && exp < 10; c++) begin
      if (c > 0) begin
        step; #1;
      end
      if (valid1) begin
        check("bp_data", dout1, 64'(exp));
        exp++;
      end
    end
    check("bp_drain", 64'(exp), 64'd10);
    repeat (3) step;
    #1;
    check("bp_no_dup", 64'(valid1), 64'd0);

    // Flush with two buffered words and one in flight
    step; ready1 = 1'b0;
    for (int i = 0; i < 10; i++) push1(64'h100 + 64'(i));
    step; #1;
    check("fl_pop_c0", 64'(pop1), 64'd1);
    step; step;
    step; #1;
    check("fl_level", 64'(lvl1), 64'd2);
    flush1 = 1'b1; #1;
    check("fl_pop_flush", 64'(pop1), 64'd0);
    step; flush1 = 1'b0;
    for (int i = 0; i < 3; i++) push1(64'h300 + 64'(i));
    #1;
    check("fl_valid_after", 64'(valid1), 64'd0);
    check("fl_level_after", 64'(lvl1), 64'd0);
    check("fl_pop_flush_q", 64'(pop1), 64'd0);
    step; #1;
    check("fl_restart_pop", 64'(pop1), 64'd1);
    ready1 = 1'b1;
    exp = 'h300;
    for (int c = 0; c < 20 && exp < 'h303; c++) begin
      step; #1;
      if (valid1) begin
        check("fl_post_data", dout1, 64'(exp));
        exp++;
      end
    end
    check("fl_post_count", 64'(exp), 64'h303);

    // Reset mid-stream
    step; ready1 = 1'b1;
    for (int i = 0; i < 20; i++) push1(64'h500 + 64'(i));
    repeat (5) step;
    #1;
    check("rm_valid_pre", 64'(valid1), 64'd1);
    for (int c = 0; c < 3; c++) begin
      step;
      if (c == 0) rst1 = 1'b1;
      #1;
      check("rm_valid_rst", 64'(valid1), 64'd0);
      check("rm_level_rst", 64'(lvl1), 64'd0);
      check("rm_pop_rst", 64'(pop1), 64'd0);
    end
    step; rst1 = 1'b0;
    for (int i = 0; i < 3; i++) push1(64'h700 + 64'(i));
    #1;
    check("rm_pop_release", 64'(pop1), 64'd0);
    step; #1;
    check("rm_pop", 64'(pop1), 64'd1);
    step; #1;
    check("rm_valid_p1", 64'(valid1), 64'd0);
    step; #1;
    check("rm_valid_p2", 64'(valid1), 64'd1);
    check("rm_data", dout1, 64'h700);
    repeat (5) step;

    // First word, latency 2
    step; ready2 = 1'b1; push2(64'hBEEF);
    step; #1;
    check("fw2_pop_t", 64'(pop2), 64'd1);
    step;
    step; #1;
    check("fw2_valid_t2", 64'(valid2), 64'd0);
    step; #1;
    check("fw2_valid_t3", 64'(valid2), 64'd1);
    check("fw2_data_t3", dout2, 64'hBEEF);
    step; step;

    // Random ready, latency 2, 1000 words
    for (int i = 0; i < 1000; i++) push2(rw(i));
    exp = 0; maxlvl = '0; stab_err = 0; prev_stall = 1'b0; prev_data = '0;
    for (int c = 0; c < 10000 && exp < 1000; c++) begin
      step;
      ready2 = 1'($urandom_range(0, 1));
      #1;
      if (prev_stall && (!valid2 || dout2 !== prev_data)) stab_err++;
      if (lvl2 > maxlvl) maxlvl = lvl2;
      if (valid2 && ready2) begin
        check("rr_data", dout2, rw(exp));
        exp++;
      end
      prev_stall = valid2 && !ready2;
      prev_data  = dout2;
    end
    check("rr_count", 64'(exp), 64'd1000);
    check("rr_level_bound", 64'(maxlvl <= 3'd4), 64'd1);
    check("rr_stable", 64'(stab_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
